// File: rtl/i_mem_loader_pkg.sv
// i_mem_loader_pkg: shared widths and loader FSM state encodings
package i_mem_loader_pkg;
  localparam int IML_ADDR_W = 9;
  localparam int IML_DATA_W = 16;
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BYTE0 = 3'd1,
    ST_BYTE1 = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;
endpackage

// File: rtl/i_mem_loader.sv
// i_mem_loader: packs a byte stream into instruction words and writes them to I_MEMORY
module i_mem_loader
  import i_mem_loader_pkg::*;
#(
  parameter int ADDR_W   = IML_ADDR_W,
  parameter int DATA_W   = IML_DATA_W,
  parameter bit HI_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done
);
  localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [7:0]        b0_q, b0_d, b1_q, b1_d;
  logic [ADDR_W:0]   cnt_clamp;
  logic              fire;
  assign cnt_clamp = (word_count > MAX_WORDS) ? MAX_WORDS : word_count;
  assign fire      = byte_valid && byte_ready;
  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end
  // next-state logic; bytes only advance the FSM on a valid/ready handshake
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = start ? ((cnt_clamp == '0) ? ST_DONE : ST_BYTE0) : ST_IDLE;
      ST_BYTE0: state_d = fire ? ST_BYTE1 : ST_BYTE0;
      ST_BYTE1: state_d = fire ? ST_WRITE : ST_BYTE1;
      ST_WRITE: state_d = (rem_q == (ADDR_W+1)'(1)) ? ST_DONE : ST_BYTE0;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end
  // datapath next values: address/count load on start, step after each write
  always_comb begin
    addr_d = addr_q;
    rem_d  = rem_q;
    b0_d   = b0_q;
    b1_d   = b1_q;
    if (state_q == ST_IDLE && start) begin
      addr_d = base_addr;
      rem_d  = cnt_clamp;
    end
    if (state_q == ST_BYTE0 && fire) b0_d = byte_in;
    if (state_q == ST_BYTE1 && fire) b1_d = byte_in;
    if (state_q == ST_WRITE) begin
      addr_d = addr_q + ADDR_W'(1);
      rem_d  = rem_q - (ADDR_W+1)'(1);
    end
  end
  // datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q <= '0;
      rem_q  <= '0;
      b0_q   <= '0;
      b1_q   <= '0;
    end else begin
      addr_q <= addr_d;
      rem_q  <= rem_d;
      b0_q   <= b0_d;
      b1_q   <= b1_d;
    end
  end
  // outputs decoded purely from state, so a write in WRITE lands even if reset hits that edge
  always_comb begin
    byte_ready = (state_q == ST_BYTE0) || (state_q == ST_BYTE1);
    mem_we     = (state_q == ST_WRITE);
    mem_addr   = addr_q;
    mem_wdata  = mem_we ? DATA_W'(HI_FIRST ? {b0_q, b1_q} : {b1_q, b0_q}) : '0;
    busy       = (state_q != ST_IDLE);
    done       = (state_q == ST_DONE);
  end
endmodule

// File: tb/tb_i_mem_loader.sv
// tb_i_mem_loader: table-driven per-cycle checks of both byte orders plus a clamp sequence
module tb_i_mem_loader;
  localparam int AW = 9;
  localparam int DW = 16;
  logic clk = 1'b0;
  logic rst_n, start, byte_valid;
  logic [AW-1:0] base_addr;
  logic [AW:0]   word_count;
  logic [7:0]    byte_in;
  logic          ready_h, we_h, busy_h, done_h;
  logic [AW-1:0] addr_h;
  logic [DW-1:0] wd_h;
  logic          ready_l, we_l, busy_l, done_l;
  logic [AW-1:0] addr_l;
  logic [DW-1:0] wd_l;
  always #5 clk = ~clk;
  i_mem_loader #(.ADDR_W(AW), .DATA_W(DW), .HI_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .word_count(word_count),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(ready_h), .mem_addr(addr_h),
    .mem_we(we_h), .mem_wdata(wd_h), .busy(busy_h), .done(done_h));
  i_mem_loader #(.ADDR_W(AW), .DATA_W(DW), .HI_FIRST(1'b0)) dut_lo (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .word_count(word_count),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(ready_l), .mem_addr(addr_l),
    .mem_we(we_l), .mem_wdata(wd_l), .busy(busy_l), .done(done_l));
  typedef enum int {T_IDLE, T_B0, T_B1, T_W, T_D} tst_e;
  typedef struct {
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base;
    logic [AW:0]   cnt;
    logic          bv;
    logic [7:0]    bin;
    tst_e          st;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
  } vec_t;
  vec_t vq[$];
  int nvec = 0;
  int nerr = 0;
  bit bad;
  task automatic push(input logic r, input logic s, input int base, input int cnt, input logic bv,
                      input int bin, input tst_e st, input int addr, input int wd);
    vec_t v;
    v.rst_n = r;
    v.start = s;
    v.base  = base[AW-1:0];
    v.cnt   = cnt[AW:0];
    v.bv    = bv;
    v.bin   = bin[7:0];
    v.st    = st;
    v.addr  = addr[AW-1:0];
    v.wd    = wd[DW-1:0];
    vq.push_back(v);
  endtask
  task automatic cmp(input string nm, input int got, input int exp);
    if (got != exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
      bad = 1'b1;
    end
  endtask
  task automatic tally(input string nm);
    nvec++;
    if (bad) begin
      nerr++;
      $display("FAIL vector %s miscompared", nm);
    end
    bad = 1'b0;
  endtask
  initial begin
    bit       seen[512];
    int       writes, dups, busy_cyc;
    bit       got_done;
    logic [DW-1:0] lo_exp;
    rst_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_in = '0; base_addr = '0; word_count = '0;
    bad = 1'b0;
    // reset state and two-word hi-first load; stray bytes in IDLE/WRITE must not be consumed
    push(1,0,0,0,0,0,     T_IDLE,0,0);
    push(1,1,0,2,1,'hEE,  T_IDLE,0,0);
    push(1,0,0,0,1,'h12,  T_B0,0,0);
    push(1,0,0,0,1,'h34,  T_B1,0,0);
    push(1,0,0,0,1,'h56,  T_W,0,'h1234);
    push(1,0,0,0,1,'h56,  T_B0,1,0);
    push(1,0,0,0,1,'h78,  T_B1,1,0);
    push(1,0,0,0,0,0,     T_W,1,'h5678);
    push(1,1,0,3,1,'h99,  T_D,2,0);
    push(1,0,0,0,0,0,     T_IDLE,2,0);
    push(1,0,0,0,0,0,     T_IDLE,2,0);
    // address wrap 510, 511, 0
    push(1,1,510,3,0,0,   T_IDLE,2,0);
    push(1,0,0,0,1,'h01,  T_B0,510,0);
    push(1,0,0,0,1,'h02,  T_B1,510,0);
    push(1,0,0,0,0,0,     T_W,510,'h0102);
    push(1,0,0,0,1,'h03,  T_B0,511,0);
    push(1,0,0,0,1,'h04,  T_B1,511,0);
    push(1,0,0,0,0,0,     T_W,511,'h0304);
    push(1,0,0,0,1,'h05,  T_B0,0,0);
    push(1,0,0,0,1,'h06,  T_B1,0,0);
    push(1,0,0,0,0,0,     T_W,0,'h0506);
    push(1,0,0,0,0,0,     T_D,1,0);
    push(1,0,0,0,0,0,     T_IDLE,1,0);
    // zero-length load
    push(1,1,7,0,0,0,     T_IDLE,1,0);
    push(1,0,0,0,0,0,     T_D,7,0);
    push(1,0,0,0,0,0,     T_IDLE,7,0);
    // gapped byte_valid and start while busy
    push(1,1,100,1,1,'hEE, T_IDLE,7,0);
    push(1,1,300,5,0,0,    T_B0,100,0);
    push(1,0,0,0,0,0,      T_B0,100,0);
    push(1,0,0,0,1,'hAA,   T_B0,100,0);
    push(1,1,300,5,0,0,    T_B1,100,0);
    push(1,0,0,0,0,0,      T_B1,100,0);
    push(1,0,0,0,1,'hBB,   T_B1,100,0);
    push(1,1,300,5,1,'hCC, T_W,100,'hAABB);
    push(1,0,0,0,0,0,      T_D,101,0);
    push(1,0,0,0,0,0,      T_IDLE,101,0);
    // reset during BYTE1 of the second word, then a fresh load
    push(1,1,20,3,0,0,    T_IDLE,101,0);
    push(1,0,0,0,1,'h11,  T_B0,20,0);
    push(1,0,0,0,1,'h22,  T_B1,20,0);
    push(1,0,0,0,0,0,     T_W,20,'h1122);
    push(1,0,0,0,1,'h33,  T_B0,21,0);
    push(0,0,0,0,1,'h44,  T_B1,21,0);
    push(1,0,0,0,0,0,     T_IDLE,0,0);
    push(1,0,0,0,1,'h55,  T_IDLE,0,0);
    push(1,1,5,1,0,0,     T_IDLE,0,0);
    push(1,0,0,0,1,'h9A,  T_B0,5,0);
    push(1,0,0,0,1,'hBC,  T_B1,5,0);
    push(1,0,0,0,0,0,     T_W,5,'h9ABC);
    push(1,0,0,0,0,0,     T_D,6,0);
    push(1,0,0,0,0,0,     T_IDLE,6,0);
    // reset coinciding with WRITE still writes, nothing follows
    push(1,1,40,2,0,0,    T_IDLE,6,0);
    push(1,0,0,0,1,'h01,  T_B0,40,0);
    push(1,0,0,0,1,'h02,  T_B1,40,0);
    push(0,0,0,0,0,0,     T_W,40,'h0102);
    push(1,0,0,0,1,'h03,  T_IDLE,0,0);
    push(1,0,0,0,0,0,     T_IDLE,0,0);
    // AB CD: hi-first 0xABCD, lo-first 0xCDAB
    push(1,1,9,1,0,0,     T_IDLE,0,0);
    push(1,0,0,0,1,'hAB,  T_B0,9,0);
    push(1,0,0,0,1,'hCD,  T_B1,9,0);
    push(1,0,0,0,0,0,     T_W,9,'hABCD);
    push(1,0,0,0,0,0,     T_D,10,0);
    push(1,0,0,0,0,0,     T_IDLE,10,0);
    repeat (2) @(posedge clk);
    foreach (vq[i]) begin
      @(negedge clk);
      rst_n = vq[i].rst_n; start = vq[i].start; base_addr = vq[i].base;
      word_count = vq[i].cnt; byte_valid = vq[i].bv; byte_in = vq[i].bin;
      #1;
      lo_exp = {vq[i].wd[7:0], vq[i].wd[15:8]};
      cmp($sformatf("v%0d byte_ready", i), int'(ready_h), int'(vq[i].st == T_B0 || vq[i].st == T_B1));
      cmp($sformatf("v%0d mem_we", i), int'(we_h), int'(vq[i].st == T_W));
      cmp($sformatf("v%0d mem_addr", i), int'(addr_h), int'(vq[i].addr));
      cmp($sformatf("v%0d mem_wdata", i), int'(wd_h), int'(vq[i].wd));
      cmp($sformatf("v%0d busy", i), int'(busy_h), int'(vq[i].st != T_IDLE));
      cmp($sformatf("v%0d done", i), int'(done_h), int'(vq[i].st == T_D));
      cmp($sformatf("v%0d lo mem_we", i), int'(we_l), int'(vq[i].st == T_W));
      cmp($sformatf("v%0d lo mem_addr", i), int'(addr_l), int'(vq[i].addr));
      cmp($sformatf("v%0d lo mem_wdata", i), int'(wd_l), int'(lo_exp));
      tally($sformatf("%0d", i));
    end
    // word_count 600 clamps to 512: every address once, wraps back to base
    @(negedge clk);
    rst_n = 1'b1; start = 1'b1; base_addr = '0; word_count = 10'd600; byte_valid = 1'b0;
    writes = 0; dups = 0; busy_cyc = 0; got_done = 1'b0;
    foreach (seen[i]) seen[i] = 1'b0;
    for (int k = 0; k < 2000 && !got_done; k++) begin
      @(negedge clk);
      start = 1'b0; byte_valid = 1'b1; byte_in = k[7:0];
      #1;
      if (busy_h) busy_cyc++;
      if (we_h) begin
        writes++;
        if (seen[addr_h]) dups++;
        seen[addr_h] = 1'b1;
      end
      if (done_h) begin
        got_done = 1'b1;
        cmp("clamp final addr", int'(addr_h), 0);
      end
    end
    byte_valid = 1'b0;
    cmp("clamp done seen", int'(got_done), 1);
    tally("clamp_done");
    cmp("clamp writes", writes, 512);
    tally("clamp_writes");
    cmp("clamp duplicate addrs", dups, 0);
    tally("clamp_dups");
    cmp("clamp busy cycles", busy_cyc, 1537);
    tally("clamp_busy");
    @(negedge clk);
    #1;
    cmp("clamp back to idle", int'(busy_h), 0);
    tally("clamp_idle");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
